// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
//   Shared types and constants for the program-counter sequencer.
//   - state_t         : sequencer FSM states (IDLE..HALT)
//   - BR_*            : branch-type encodings carried on tipo_branch
//   - PC_SEQ_RESET_PC : default PC loaded on reset
// ---------------------------------------------------------------------------
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_RESOLVE = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  localparam logic [2:0] BR_REL  = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_JAL  = 3'd6;
  localparam logic [2:0] BR_REL7 = 3'd7;

  localparam int unsigned PC_SEQ_RESET_PC = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
//   Combinational branch-condition evaluator.
//   Ports:
//     tipo_branch in  3  branch type (BR_* encodings)
//     zero        in  1  ALU result was zero
//     neg         in  1  ALU result was negative (signed a<b)
//     borrow      in  1  unsigned a<b
//     cond        out 1  branch condition holds for this type
// ---------------------------------------------------------------------------
module branch_cond_eval
  import pc_seq_pkg::*;
(
  input  logic [2:0] tipo_branch,
  input  logic       zero,
  input  logic       neg,
  input  logic       borrow,
  output logic       cond
);

  always_comb begin
    cond = 1'b1;
    case (tipo_branch)
      BR_BEQ:  cond = zero;
      BR_BNE:  cond = ~zero;
      BR_BLT:  cond = neg;
      BR_BGE:  cond = zero | ~neg;
      BR_BLTU: cond = borrow;
      default: cond = 1'b1;  // BR_REL, BR_JAL, BR_REL7 are unconditional
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Multi-cycle control FSM owning the program counter. Sequences
//   FETCH -> DECODE -> EXEC -> RESOLVE -> FETCH, evaluates the branch
//   condition from latched ALU flags and updates the PC. Halts on a halt
//   instruction or on a fetch timeout (sticky fetch_err).
//   Optional feature macro: PC_SEQ_STATS_EN (saturating branch counters;
//   when undefined the stat_* ports are tied to zero).
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     start                 leave IDLE and begin fetching
//     mem_ready             instruction word valid (FETCH handshake)
//     is_branch, is_halt    decoded instruction class (sampled in DECODE)
//     tipo_branch, imed     branch type and offset/target (sampled in DECODE)
//     zero, neg, borrow     ALU flags (sampled in EXEC)
//     pc                    current program counter
//     fetch_req             request instruction at pc
//     pc_src                last resolve took a branch
//     halted                in HALT
//     fetch_err             sticky fetch-timeout flag
//     stat_taken/stat_total taken / resolved branch counts
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     PC_W          = 32,
  parameter logic [PC_W-1:0] RESET_PC      = PC_W'(PC_SEQ_RESET_PC),
  parameter int unsigned     FETCH_TIMEOUT = 15,
  parameter int unsigned     CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mem_ready,
  input  logic             is_branch,
  input  logic             is_halt,
  input  logic [2:0]       tipo_branch,
  input  logic [PC_W-1:0]  imed,
  input  logic             zero,
  input  logic             neg,
  input  logic             borrow,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_req,
  output logic             pc_src,
  output logic             halted,
  output logic             fetch_err,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_total
);

  localparam int unsigned TO_W = $clog2(FETCH_TIMEOUT + 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [PC_W-1:0]   r_pc;
  logic              r_pc_src;
  logic              r_fetch_err;
  logic [TO_W-1:0]   r_to_cnt;
  logic [TO_W-1:0]   w_to_next;
  logic              w_timeout;
  logic              r_is_branch;
  logic [2:0]        r_tipo;
  logic [PC_W-1:0]   r_imed;
  logic              r_zero;
  logic              r_neg;
  logic              r_borrow;
  logic              w_cond;
  logic              w_taken;
  logic [PC_W-1:0]   w_pc_next;

  assign w_to_next = r_to_cnt + 1'b1;
  assign w_timeout = (w_to_next == TO_W'(FETCH_TIMEOUT));

  branch_cond_eval u_cond (
    .tipo_branch (r_tipo),
    .zero        (r_zero),
    .neg         (r_neg),
    .borrow      (r_borrow),
    .cond        (w_cond)
  );

  assign w_taken = r_is_branch & w_cond;

  always_comb begin
    w_pc_next = r_pc + PC_W'(1);
    if (w_taken) begin
      w_pc_next = (r_tipo == BR_JAL) ? r_imed : (r_pc + r_imed);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_next = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)      w_state_next = ST_DECODE;
        else if (w_timeout) w_state_next = ST_HALT;
      end
      ST_DECODE:  w_state_next = is_halt ? ST_HALT : ST_EXEC;
      ST_EXEC:    w_state_next = ST_RESOLVE;
      ST_RESOLVE: w_state_next = ST_FETCH;
      ST_HALT:    w_state_next = ST_HALT;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_pc_src    <= 1'b0;
      r_fetch_err <= 1'b0;
      r_to_cnt    <= '0;
      r_is_branch <= 1'b0;
      r_tipo      <= '0;
      r_imed      <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_borrow    <= 1'b0;
    end else begin
      // Timeout counter only runs while waiting in FETCH; every other state
      // holds it at zero so each FETCH entry starts a fresh window.
      if (r_state == ST_FETCH) begin
        if (mem_ready) begin
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= w_to_next;
          if (w_timeout) r_fetch_err <= 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end

      if (r_state == ST_DECODE) begin
        r_is_branch <= is_branch;
        r_tipo      <= tipo_branch;
        r_imed      <= imed;
      end

      if (r_state == ST_EXEC) begin
        r_zero   <= zero;
        r_neg    <= neg;
        r_borrow <= borrow;
      end

      if (r_state == ST_RESOLVE) begin
        r_pc     <= w_pc_next;
        r_pc_src <= w_taken;
      end
    end
  end

`ifdef PC_SEQ_STATS_EN
  logic [CNT_W-1:0] r_stat_taken;
  logic [CNT_W-1:0] r_stat_total;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_taken <= '0;
      r_stat_total <= '0;
    end else if ((r_state == ST_RESOLVE) && r_is_branch) begin
      if (r_stat_total != '1) r_stat_total <= r_stat_total + 1'b1;
      if (w_taken && (r_stat_taken != '1)) r_stat_taken <= r_stat_taken + 1'b1;
    end
  end

  assign stat_taken = r_stat_taken;
  assign stat_total = r_stat_total;
`else
  assign stat_taken = '0;
  assign stat_total = '0;
`endif

  assign pc        = r_pc;
  assign pc_src    = r_pc_src;
  assign fetch_err = r_fetch_err;
  assign fetch_req = (r_state == ST_FETCH);
  assign halted    = (r_state == ST_HALT);

endmodule
